// File: rtl/seq_mul_z.sv
// ---------------------------------------------------------------------------
// seq_mul_z
//
// Iterative shift-add multiplier. It multiplies two unsigned (DW+1)-bit
// operands and produces a (2*DW+2)-bit product. The work takes DW+1 clock
// iterations. A new product is announced with a one-cycle z_valid pulse,
// which drives the enable of the downstream seek_cd block.
//
// Ports
//   clk      in   1        system clock, rising edge
//   reset    in   1        asynchronous reset, active low
//   start    in   1        begin a multiply (sampled only while idle)
//   a        in   DW+1     multiplicand, unsigned, captured on acceptance
//   b        in   DW+1     multiplier, unsigned, captured on acceptance
//   abort    in   1        synchronous cancel of an in-flight multiply
//   busy     out  1        high while an iteration sequence is running
//   z        out  2*DW+2   product, held until the next completion
//   z_valid  out  1        one-cycle pulse marking a new z
// ---------------------------------------------------------------------------
module seq_mul_z #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DW:0]       a,
    input  logic [DW:0]       b,
    input  logic              abort,
    output logic              busy,
    output logic [2*DW+1:0]   z,
    output logic              z_valid
);

    localparam int PW = 2 * DW + 2;      // product / accumulator width
    localparam int CW = $clog2(DW + 2);  // iteration counter width

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_reg,   state_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic [PW-1:0] mcand_reg,   mcand_next;
    logic [DW:0]   mplier_reg,  mplier_next;
    logic [PW-1:0] acc_reg,     acc_next;
    logic [PW-1:0] z_reg,       z_next;
    logic          z_valid_reg, z_valid_next;

    // The partial product for this iteration is the shifted multiplicand,
    // gated by the current low bit of the multiplier.
    logic [PW-1:0] addend;
    logic [PW-1:0] acc_sum;
    logic          last_iter;

    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // The largest product fits in PW bits, so no carry-out is kept.
    assign acc_sum   = acc_reg + addend;
    assign last_iter = (cnt_reg == CW'(DW));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        z_next       = z_reg;
        z_valid_next = 1'b0;  // pulse: cleared on every edge unless set below

        case (state_reg)
            IDLE: begin
                // start takes priority over abort here; abort does nothing in IDLE.
                if (start) begin
                    mcand_next  = {{(PW - DW - 1){1'b0}}, a};
                    mplier_next = b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    // Even on the final iteration, abort drops the result.
                    // z keeps its old value.
                    state_next = IDLE;
                end else begin
                    acc_next    = acc_sum;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg + CW'(1);
                    if (last_iter) begin
                        z_next       = acc_sum;
                        z_valid_next = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            z_reg       <= '0;
            z_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            z_reg       <= z_next;
            z_valid_reg <= z_valid_next;
        end
    end

    assign busy    = (state_reg == BUSY);
    assign z       = z_reg;
    assign z_valid = z_valid_reg;

endmodule

// File: tb/tb_seq_mul_z.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_z
//
// Directed testbench for seq_mul_z with DW=32. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge. Every expected
// value below was worked out by hand.
// ---------------------------------------------------------------------------
module tb_seq_mul_z;

    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [DW:0]     a;
    logic [DW:0]     b;
    logic            abort;
    logic            busy;
    logic [2*DW+1:0] z;
    logic            z_valid;

    int checks = 0;
    int errors = 0;

    seq_mul_z #(.DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .busy    (busy),
        .z       (z),
        .z_valid (z_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands with start at a falling edge. The multiply is
    // accepted at the next rising edge (E0). Return at the falling edge
    // just after E0.
    task automatic launch(input logic [DW:0] aa, input logic [DW:0] bb);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count the busy falling edges that remain, with a bounded wait. Then
    // check the completion. Return at the falling edge where z_valid should
    // be high.
    task automatic wait_done(input string tag, input logic [65:0] exp, input int exp_cycles);
        int n = 0;
        logic early = 1'b0;
        while (busy && n < 60) begin
            if (z_valid) early = 1'b1;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_busy_cycles"}, 66'(n), 66'(exp_cycles));
        check_eq({tag, "_no_early_valid"}, 66'(early), 66'd0);
        check_eq({tag, "_valid"}, 66'(z_valid), 66'd1);
        check_eq({tag, "_z"}, z, exp);
        $display("mul %s: z=%0h z_valid=%0b busy_cycles=%0d", tag, z, z_valid, n);
    endtask

    // Step one edge past completion: the pulse must clear and z must hold.
    task automatic check_after(input string tag, input logic [65:0] exp);
        @(negedge clk);
        check_eq({tag, "_valid_clr"}, 66'(z_valid), 66'd0);
        check_eq({tag, "_z_hold"}, z, exp);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 66'(busy), 66'd0);
        check_eq("rst_z", z, 66'd0);
        check_eq("rst_valid", 66'(z_valid), 66'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic product: 33 busy cycles, then a single pulse.
        launch(33'd3, 33'd5);
        wait_done("3x5", 66'd15, 33);
        check_after("3x5", 66'd15);
        repeat (3) @(negedge clk);
        check_eq("3x5_z_stable", z, 66'd15);

        // Largest operands.
        launch({33{1'b1}}, {33{1'b1}});
        wait_done("max", 66'h3_FFFF_FFFC_0000_0001, 33);
        check_eq("max_top7", 66'(z[65:59]), 66'h7F);
        check_after("max", 66'h3_FFFF_FFFC_0000_0001);

        // A zero multiplicand gives 0. Then a single high bit is shifted.
        launch(33'd0, 33'h1_2345_6789);
        wait_done("zero", 66'd0, 33);
        check_after("zero", 66'd0);
        launch(33'h1_0000_0000, 33'd2);
        wait_done("pow33", 66'h2_0000_0000, 33);
        check_after("pow33", 66'h2_0000_0000);

        // A start pulse while busy is ignored. Operand changes while busy
        // are ignored too.
        launch(33'd3, 33'd5);
        repeat (5) @(negedge clk);
        a     = 33'd7;
        b     = 33'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 66'd15, 27);
        // A start in the z_valid cycle is accepted back to back.
        launch(33'd7, 33'd7);
        check_eq("b2b_accept_busy", 66'(busy), 66'd1);
        wait_done("b2b", 66'd49, 33);
        check_after("b2b", 66'd49);

        // Abort mid-run: busy drops after one edge and z is unchanged.
        launch(33'd9, 33'd9);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 66'(busy), 66'd0);
        check_eq("abort_valid", 66'(z_valid), 66'd0);
        check_eq("abort_z", z, 66'd49);
        repeat (30) begin
            @(negedge clk);
            if (z_valid) check_eq("abort_late_valid", 66'(z_valid), 66'd0);
        end
        check_eq("abort_z_later", z, 66'd49);
        launch(33'd2, 33'd2);
        wait_done("2x2", 66'd4, 33);
        check_after("2x2", 66'd4);

        // start and abort together in IDLE: start wins.
        a     = 33'd5;
        b     = 33'd5;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_wins_busy", 66'(busy), 66'd1);
        wait_done("5x5", 66'd25, 33);
        check_after("5x5", 66'd25);

        // Asynchronous reset between clock edges in the middle of a run.
        launch(33'd9, 33'd9);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_busy", 66'(busy), 66'd0);
        check_eq("async_rst_z", z, 66'd0);
        check_eq("async_rst_valid", 66'(z_valid), 66'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 66'(busy), 66'd0);
        launch(33'd6, 33'd7);
        wait_done("6x7", 66'd42, 33);
        check_after("6x7", 66'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul_z.md
Name: seq_mul_z

Overview:
- Iterative shift-add multiplier that produces the 2*`Datawidth+2`-bit product word `z` consumed by seek_cd.
- Takes two unsigned (`Datawidth`+1)-bit operands and computes their full product over `Datawidth`+1 iterations.
- Presents the result on `z` with a one-cycle `z_valid` pulse that drives seek_cd's `en`.
- Sits directly upstream of seek_cd in the same clock domain.

Parameters:
- DW, default `Datawidth` (32 from defines.v): operand magnitude width. Operands are DW+1 bits; product is 2*DW+2 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiply. Sampled only while idle.
- a  input  DW+1  multiplicand, unsigned. Captured at the accepting edge.
- b  input  DW+1  multiplier, unsigned. Captured at the accepting edge.
- abort  input  1  synchronous cancel of an in-flight multiply.
- busy  output  1  high while an iteration sequence is in progress.
- z  output  2*DW+2  product a*b. Held until the next completion.
- z_valid  output  1  one-cycle pulse marking a new `z`. Connects to seek_cd `en`.

Behaviour:
- Reset: one clock; reset asynchronous, active-low (reset=0 clears immediately, independent of clk). All outputs and internal state reset to 0: busy=0, z=0, z_valid=0, state=IDLE, cnt=0, acc=0, internal operand registers=0.
- States:
  - IDLE: busy=0. If start=1 at a rising edge, capture a into mcand (zero-extended to 2*DW+2 bits) and b into mplier. Clear acc and cnt, go to BUSY.
  - BUSY: busy=1. Each edge does one iteration: if mplier[0]=1 then acc <= acc + mcand. Then mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
    - On the edge where cnt==DW (iteration DW+1, the last): z <= final acc including that iteration's add, z_valid <= 1, go to IDLE.
- Latency: accepting edge E0; result edge E(DW+1). z_valid is high in the cycle after E(DW+1) = 33 edges after E0 for DW=32. busy is high in cycles E0..E(DW+1)-1.
- z_valid is a single-cycle pulse, cleared at the next edge unconditionally.
- z is stable from E(DW+1) until the next completion; it is not cleared by start or abort. seek_cd therefore samples a stable `z` while `en` is high.
- Arithmetic:
  - acc is 2*DW+2 bits. Max product (2^(DW+1)-1)^2 < 2^(2*DW+2), so no overflow and no carry-out is needed.
  - mcand shifts are truncated to 2*DW+2 bits.
  - cnt is ceil(log2(DW+2)) bits.
- start while BUSY: ignored; operands are not re-captured and there is no queueing.
- start in the cycle z_valid=1: state is IDLE, so it is accepted (back-to-back throughput of one result per DW+2 cycles).
- abort=1 in BUSY: next edge returns to IDLE with busy=0, z_valid stays 0 and z unchanged. abort in IDLE has no effect.
- abort and start both high in IDLE: start wins.
- abort on the final-iteration edge: abort wins; no z update and no z_valid.
- Reset mid-operation: returns to the reset values immediately. No z_valid is emitted for the lost operation.
- a/b changing during BUSY does not affect the result.

Test Plan:
- Reset, then a=3, b=5, start pulse -> busy=1 for 33 cycles; z=15 with z_valid=1 for exactly 1 cycle at E0+33; z stays 15 afterward.
- a=b=2^33-1 -> z=0x3_FFFF_FFFC_0000_0001 (2^66-2^34+1) and z_valid pulse; z[65:59] matches the top 7 bits.
- a=0, b=0x1_2345_6789 -> z=0 with z_valid pulse. Then a=0x1_0000_0000, b=2 -> z=2^33.
- start re-pulsed with a=7, b=7 while busy after a=3, b=5 -> ignored, z=15. Then start in the z_valid cycle with a=7, b=7 -> accepted, z=49 at 33 edges later.
- abort at cycle 10 of a=9, b=9 -> busy drops next edge, no z_valid, z keeps its previous value. A following start with a=2, b=2 completes with z=4.
- reset=0 asserted asynchronously mid-BUSY (between edges) -> busy, z, z_valid = 0 immediately. After release, start with a=6, b=7 -> z=42.
